// File: rtl/branch_ctrl_pkg.sv
// Shared branch-controller types, constants and the funct3 resolve helper.
package branch_ctrl_pkg;

  localparam int unsigned BR_CNT_W = 16;
  localparam logic [1:0]  BHT_INIT = 2'b01;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_func_e;

  typedef struct packed {
    logic taken;
    logic illegal;
  } br_res_t;

  // Flags come from rs1 - rs2; carry set means no borrow (rs1 >= rs2 unsigned).
  function automatic br_res_t br_resolve(input logic [2:0] f3, input logic zero,
                                         input logic carry, input logic overflow,
                                         input logic sign);
    br_res_t r;
    r = '0;
    case (f3)
      BR_BEQ:  r.taken = zero;
      BR_BNE:  r.taken = ~zero;
      BR_BLT:  r.taken = sign ^ overflow;
      BR_BGE:  r.taken = ~(sign ^ overflow);
      BR_BLTU: r.taken = ~carry;
      BR_BGEU: r.taken = carry;
      default: r.illegal = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// ID/EX branch request and redirect/flush response bundle of branch_ctrl.
interface branch_ctrl_if;
  import branch_ctrl_pkg::*;

  logic                id_valid;
  logic                id_is_branch;
  logic [31:0]         id_pc;
  logic                id_pred_taken;
  logic                ex_valid;
  logic                ex_is_branch;
  logic                ex_stall;
  logic [31:0]         ex_pc;
  logic [31:0]         ex_target;
  logic                ex_pred_taken;
  logic [2:0]          ex_func3;
  logic                ex_zero;
  logic                ex_carry;
  logic                ex_overflow;
  logic                ex_sign;
  logic                redirect;
  logic [31:0]         redirect_pc;
  logic                flush;
  logic                illegal_br;
  logic [BR_CNT_W-1:0] br_count;
  logic [BR_CNT_W-1:0] mispred_count;

  modport master (
    output id_valid, id_is_branch, id_pc,
    output ex_valid, ex_is_branch, ex_stall, ex_pc, ex_target, ex_pred_taken,
    output ex_func3, ex_zero, ex_carry, ex_overflow, ex_sign,
    input  id_pred_taken, redirect, redirect_pc, flush, illegal_br,
    input  br_count, mispred_count
  );

  modport slave (
    input  id_valid, id_is_branch, id_pc,
    input  ex_valid, ex_is_branch, ex_stall, ex_pc, ex_target, ex_pred_taken,
    input  ex_func3, ex_zero, ex_carry, ex_overflow, ex_sign,
    output id_pred_taken, redirect, redirect_pc, flush, illegal_br,
    output br_count, mispred_count
  );
endinterface

// File: rtl/branch_bht.sv
// Table of 2-bit saturating counters: async read port, synchronous update port.
module branch_bht
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] ctr [ENTRIES];

  // Read sees the pre-update value when it hits the entry being written.
  assign rd_ctr = ctr[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) ctr[i] <= BHT_INIT;
    end else if (wr_en) begin
      if (wr_taken && ctr[wr_idx] != 2'b11)
        ctr[wr_idx] <= ctr[wr_idx] + 2'b01;
      else if (!wr_taken && ctr[wr_idx] != 2'b00)
        ctr[wr_idx] <= ctr[wr_idx] - 2'b01;
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch prediction lookup, EX resolution, redirect/flush generation and stats.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned BHT_ENTRIES = 16,
  parameter int unsigned IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic           clk,
  input  logic           rst,
  branch_ctrl_if.slave   bus
);

  logic [1:0]          rd_ctr;
  br_res_t             res;
  logic                resolve;
  logic                mispred;
  logic                redirect_q;
  logic                illegal_q;
  logic [31:0]         redirect_pc_q;
  logic [BR_CNT_W-1:0] br_cnt_q;
  logic [BR_CNT_W-1:0] mis_cnt_q;

  branch_bht #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (bus.id_pc[IDX_W+1:2]),
    .rd_ctr   (rd_ctr),
    .wr_en    (resolve),
    .wr_idx   (bus.ex_pc[IDX_W+1:2]),
    .wr_taken (res.taken)
  );

  always_comb begin
    res = br_resolve(bus.ex_func3, bus.ex_zero, bus.ex_carry, bus.ex_overflow, bus.ex_sign);
    // A branch in EX during the flush cycle is a squashed shadow; stall alone defers it.
    resolve = bus.ex_valid & bus.ex_is_branch & ~bus.ex_stall & ~redirect_q;
    mispred = resolve & (res.taken != bus.ex_pred_taken);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      illegal_q     <= 1'b0;
      br_cnt_q      <= '0;
      mis_cnt_q     <= '0;
    end else begin
      redirect_q    <= mispred;
      redirect_pc_q <= mispred ? (res.taken ? bus.ex_target : bus.ex_pc + 32'd4) : '0;
      illegal_q     <= resolve & res.illegal;
      if (resolve && br_cnt_q != '1) br_cnt_q <= br_cnt_q + 1'b1;
      if (mispred && mis_cnt_q != '1) mis_cnt_q <= mis_cnt_q + 1'b1;
    end
  end

  assign bus.id_pred_taken = bus.id_valid & bus.id_is_branch & rd_ctr[1];
  assign bus.redirect      = redirect_q;
  assign bus.flush         = redirect_q;
  assign bus.redirect_pc   = redirect_pc_q;
  assign bus.illegal_br    = illegal_q;
  assign bus.br_count      = br_cnt_q;
  assign bus.mispred_count = mis_cnt_q;

endmodule
